// File: rtl/pkg_timer_bank.sv
// Bank of independent down-counting timers with periodic/one-shot modes and single-cycle expiry ticks.
// Latency: commands take effect at the accepting edge; tick, cmd_err and rd_data are registered (1 cycle).
// Backpressure: none; a command is accepted every cycle cmd_valid is high.
package timer_pkg;
    localparam int DEFAULT_RELOAD = 3;
    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_MODE  = 2'd3;
endpackage

module pkg_timer_bank #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 16,
    parameter int DEFAULT_RELOAD = timer_pkg::DEFAULT_RELOAD,
    localparam int CHAN_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd_op,
    input  logic [CHAN_BITS-1:0] cmd_chan,
    input  logic [WIDTH-1:0]     cmd_data,
    output logic                 cmd_err,
    input  logic [CHAN_BITS-1:0] rd_chan,
    output logic [WIDTH-1:0]     rd_data,
    output logic [CHANNELS-1:0]  running,
    output logic [CHANNELS-1:0]  tick
);
    import timer_pkg::*;

    localparam logic [WIDTH-1:0]   RST_VAL = WIDTH'(DEFAULT_RELOAD);
    localparam logic [CHAN_BITS:0] NUM_CH  = (CHAN_BITS + 1)'(CHANNELS);

    logic [WIDTH-1:0]    count_q  [CHANNELS];
    logic [WIDTH-1:0]    count_d  [CHANNELS];
    logic [WIDTH-1:0]    reload_q [CHANNELS];
    logic [WIDTH-1:0]    reload_d [CHANNELS];
    logic [CHANNELS-1:0] run_q, run_d;
    logic [CHANNELS-1:0] oneshot_q, oneshot_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic                err_q, err_d;
    logic [WIDTH-1:0]    rd_q, rd_d;
    logic                chan_ok;
    logic                hit;

    assign chan_ok = ({1'b0, cmd_chan} < NUM_CH);

    always_comb begin
        count_d   = count_q;
        reload_d  = reload_q;
        run_d     = run_q;
        oneshot_d = oneshot_q;
        tick_d    = '0;
        err_d     = cmd_valid && !chan_ok;
        rd_d      = '0;
        hit       = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit = cmd_valid && chan_ok && (cmd_chan == CHAN_BITS'(i));
            if (rd_chan == CHAN_BITS'(i)) begin
                rd_d = count_q[i];
            end
            // A command to a channel pre-empts its counting for that cycle.
            if (hit) begin
                case (cmd_op)
                    OP_LOAD:  reload_d[i] = cmd_data;
                    OP_START: begin
                        count_d[i] = reload_q[i];
                        run_d[i]   = 1'b1;
                    end
                    OP_STOP:  run_d[i] = 1'b0;
                    OP_MODE:  oneshot_d[i] = cmd_data[0];
                    default:  ;
                endcase
            end else if (run_q[i] && (count_q[i] == '0)) begin
                tick_d[i] = 1'b1;
                if (oneshot_q[i]) begin
                    run_d[i] = 1'b0;
                end else begin
                    count_d[i] = reload_q[i];
                end
            end else if (run_q[i]) begin
                count_d[i] = count_q[i] - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]  <= RST_VAL;
                reload_q[i] <= RST_VAL;
            end
            run_q     <= '0;
            oneshot_q <= '0;
            tick_q    <= '0;
            err_q     <= 1'b0;
            rd_q      <= '0;
        end else begin
            count_q   <= count_d;
            reload_q  <= reload_d;
            run_q     <= run_d;
            oneshot_q <= oneshot_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
        end
    end

    assign cmd_err = err_q;
    assign rd_data = rd_q;
    assign running = run_q;
    assign tick    = tick_q;

endmodule
